mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have no parameters; sizes are fixed by this document.
REQ-002 Clk  input  1  rising-edge clock shared with data memory.
REQ-003 Rst  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 Req  input  1  memory operation presented this cycle.
REQ-005 IsStore  input  1  1 = store, 0 = load.
REQ-006 Size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-007 SignedLoad  input  1  1 = sign-extend sub-word loads, 0 = zero-extend.
REQ-008 Addr  input  32  byte address.
REQ-009 StoreData  input  32  store value, right-aligned for sub-word sizes.
REQ-010 Ready  output  1  operation accepted this cycle when Req && Ready.
REQ-011 LoadData  output  32  extended load result.
REQ-012 LoadValid  output  1  one-cycle pulse when LoadData is new.
REQ-013 AlignErr  output  1  one-cycle pulse for a misaligned or illegal request.
REQ-014 MemAddr  output  32  word-aligned address to data memory.
REQ-015 MemWriteData  output  32  word written to data memory.
REQ-016 MemWrite / MemRead  output  1 each  data memory strobes.
REQ-017 MemReadData  input  32  combinational read word from data memory.

Function
REQ-018 SHALL implement states IDLE and MERGE; Ready = 1 only in IDLE.
REQ-019 Accept = Req && Ready; MemAddr SHALL be {Addr[31:2],2'b00} in the accept cycle and the registered word address in MERGE; all memory strobes SHALL be 0 otherwise.
REQ-020 Byte lanes SHALL be little-endian: lane k = bits 8k+7:8k, selected by Addr[1:0]; halfword lane = Addr[1].
REQ-021 Misaligned requests SHALL raise AlignErr on the next edge for one cycle, with no MemRead or MemWrite, no LoadValid, and no state change: Size=01 with Addr[0]=1, Size=10 with Addr[1:0]!=0, or Size=11.
REQ-022 Load accept SHALL assert MemRead, extract and extend the addressed lane combinationally, register it into LoadData at the edge, and pulse LoadValid the following cycle (latency 1).
REQ-023 LoadData SHALL hold its value until the next load completes.
REQ-024 Word store accept SHALL assert MemWrite with MemWriteData = StoreData in the same cycle and remain in IDLE.
REQ-025 Sub-word store accept SHALL assert MemRead, capture MemReadData merged with StoreData[7:0] or StoreData[15:0] into the selected lane, register the word address, and enter MERGE.
REQ-026 MERGE SHALL assert MemWrite with the merged word for exactly one cycle and then return to IDLE; sub-word store occupancy is 2 cycles.
REQ-027 Req during MERGE SHALL NOT be accepted; the requester holds Req and its inputs until Ready.
REQ-028 Back-to-back accepts in consecutive IDLE cycles SHALL be supported with no bubble for loads and word stores.

Reset
REQ-029 Reset SHALL force state IDLE, LoadData = 0, LoadValid = 0, AlignErr = 0, and the merge and address registers to 0.
REQ-030 Reset during MERGE SHALL abandon the pending write, with no MemWrite after reset assertion.
REQ-031 Ready SHALL be 1 on the first cycle after reset deasserts.

Structure
REQ-032 A shared package SHALL hold the Size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the state encodings.
REQ-033 One sub-module, lane_extract (combinational: word, Addr[1:0], Size, SignedLoad -> extended value), SHALL be instantiated; the merge logic stays inline.

Verification
REQ-034 Memory word 0x0 = 0x8899AABB; load byte signed at Addr 0x1 -> LoadValid next cycle, LoadData = 0xFFFFFFAA; unsigned -> 0x000000AA.
REQ-035 Store byte 0x5C at Addr 0x2 over 0x8899AABB -> Ready low one cycle, one MemWrite of 0x885CAABB to MemAddr 0x0; a following load word returns 0x885CAABB.
REQ-036 Store halfword 0x1234 at Addr 0x6 over 0x00000000 -> memory word 1 = 0x12340000; a load halfword signed at 0x6 -> 0x00001234.
REQ-037 Load word at Addr 0x5 and Size=11 at Addr 0x0 -> one AlignErr pulse each, no MemRead or MemWrite, LoadValid stays 0.
REQ-038 Assert Rst low in the MERGE cycle of a byte store -> memory unchanged, all outputs 0, Ready = 1 after release.
REQ-039 Three back-to-back load word requests at 0x0, 0x4, 0x8 -> Ready stays 1 and LoadValid is high on 3 consecutive cycles with matching data.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg
// Shared encodings for the memory access unit: access sizes, FSM states and
// the alignment rule used by the top level.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_WORD    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } sizeE;

  typedef enum logic {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } stateE;

  // A request is rejected when the address is not naturally aligned for its
  // size, or when the size code is the unused one.
  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addrLo[0];
      SZ_WORD: bad = (addrLo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_extract.sv
// lane_extract
// Combinational load lane selection and extension (little-endian lanes).
// Ports:
//   Word       - 32-bit word read from data memory
//   AddrLo     - byte offset within the word (Addr[1:0])
//   Size       - access size code
//   SignedLoad - 1 sign-extends sub-word values, 0 zero-extends
//   Value      - right-aligned, extended result
module lane_extract
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] Word,
  input  logic [1:0]  AddrLo,
  input  logic [1:0]  Size,
  input  logic        SignedLoad,
  output logic [31:0] Value
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    byteSel = Word[{AddrLo, 3'b000} +: 8];
    halfSel = AddrLo[1] ? Word[31:16] : Word[15:0];
    case (Size)
      SZ_BYTE: Value = {{24{SignedLoad & byteSel[7]}}, byteSel};
      SZ_HALF: Value = {{16{SignedLoad & halfSel[15]}}, halfSel};
      default: Value = Word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Load/store unit in front of a word-wide data memory with a combinational
// read port. Loads and word stores complete in the accept cycle; sub-word
// stores read the word, merge the new lane and write it back one cycle later.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready; loads and word stores issue directly, sub-word store reads
// MERGE | write back the merged word captured in IDLE, Ready low
//
// Ports:
//   Clk, Rst (active-low async)
//   Req, IsStore, Size, SignedLoad, Addr, StoreData - request side
//   Ready, LoadData, LoadValid, AlignErr             - response side
//   MemAddr, MemWriteData, MemWrite, MemRead, MemReadData - data memory
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Req,
  input  logic        IsStore,
  input  logic [1:0]  Size,
  input  logic        SignedLoad,
  input  logic [31:0] Addr,
  input  logic [31:0] StoreData,
  output logic        Ready,
  output logic [31:0] LoadData,
  output logic        LoadValid,
  output logic        AlignErr,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWriteData,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [31:0] MemReadData
);

  stateE       state, stateNext;
  logic        accept, misaligned, goodAccept;
  logic        isLoad, isSubStore;
  logic [31:0] wordAddr, extValue, mergeNext;
  logic [31:0] mergeQ, addrQ;

  assign Ready      = (state == IDLE);
  assign accept     = Req && (state == IDLE);
  assign misaligned = isMisaligned(Size, Addr[1:0]);
  assign goodAccept = accept && !misaligned;
  assign isLoad     = goodAccept && !IsStore;
  assign isSubStore = goodAccept && IsStore && (Size != SZ_WORD);
  assign wordAddr   = {Addr[31:2], 2'b00};

  lane_extract uExtract (
    .Word       (MemReadData),
    .AddrLo     (Addr[1:0]),
    .Size       (Size),
    .SignedLoad (SignedLoad),
    .Value      (extValue)
  );

  // Read-modify-write: drop the new lane into the word just read.
  always_comb begin
    mergeNext = MemReadData;
    case (Size)
      SZ_BYTE: mergeNext[{Addr[1:0], 3'b000} +: 8] = StoreData[7:0];
      SZ_HALF: begin
        if (Addr[1]) mergeNext[31:16] = StoreData[15:0];
        else         mergeNext[15:0]  = StoreData[15:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    stateNext    = state;
    MemAddr      = 32'h0;
    MemWriteData = 32'h0;
    MemWrite     = 1'b0;
    MemRead      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) MemAddr = wordAddr;
        if (goodAccept) begin
          if (!IsStore) begin
            MemRead = 1'b1;
          end else if (Size == SZ_WORD) begin
            MemWrite     = 1'b1;
            MemWriteData = StoreData;
          end else begin
            MemRead   = 1'b1;
            stateNext = MERGE;
          end
        end
      end
      MERGE: begin
        MemAddr      = addrQ;
        MemWrite     = 1'b1;
        MemWriteData = mergeQ;
        stateNext    = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Async reset also clears the state immediately, so a pending MERGE write
  // disappears from the strobes as soon as Rst falls.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= IDLE;
    else      state <= stateNext;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      LoadData  <= 32'h0;
      LoadValid <= 1'b0;
      AlignErr  <= 1'b0;
      mergeQ    <= 32'h0;
      addrQ     <= 32'h0;
    end else begin
      LoadValid <= isLoad;
      AlignErr  <= accept && misaligned;
      if (isLoad) LoadData <= extValue;
      if (isSubStore) begin
        mergeQ <= mergeNext;
        addrQ  <= wordAddr;
      end
    end
  end

endmodule
